cpu_bus_bridge: RTL and testbench

Bridges the 6502 core's bus (clocked by clkPhi0) to the PSRAM memory controller (clocked by clkSys). Sits directly upstream of memCtrl and replaces the standalone RAM-test sequencer as its single requester. Each CPU bus cycle becomes exactly one memCtrl transaction. The bridge stalls the CPU via RDY until the controller completes, or until a timeout aborts the transaction.

---
 rtl/cpu_bus_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_cpu_bus_bridge.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_bridge.sv
// cpu_bus_bridge
//   Turns each 6502 bus cycle (phi0 rising edge) into one memCtrl
//   transaction. RDY stalls the CPU until memCtrl completes or the
//   transaction times out.
//
//   Optional feature: GM64_VECTOR_OVERRIDE_EN. When defined, CPU reads of
//   $FFFC/$FFFD return RESET_VECTOR bytes without touching memCtrl.
//
// Ports
//   clkSys          system clock (only clock)
//   reset           asynchronous active-low reset
//   i_phi0          phi0 level, sampled; a rising edge raises a request
//   i_addr/i_we/i_cpuData   CPU address, write enable, write data
//   o_cpuData       read data to CPU
//   o_rdy           CPU RDY (low while a transaction is outstanding)
//   o_cs            memCtrl chip select, active-low, one-cycle pulse
//   o_write/o_address/o_dataToWrite   memCtrl request fields
//   i_dataRead/i_busy/i_dataReady     memCtrl response
//   o_error         sticky timeout flag
//   o_accessCount   completed (non-aborted) transaction count
module cpu_bus_bridge #(
  parameter logic [23:0] BASE_ADDR    = 24'h000000,
  parameter logic [15:0] TIMEOUT      = 16'd1024,
  parameter logic [15:0] RESET_VECTOR = 16'h0300
) (
  input  logic        clkSys,
  input  logic        reset,
  input  logic        i_phi0,
  input  logic [15:0] i_addr,
  input  logic        i_we,
  input  logic [7:0]  i_cpuData,
  output logic [7:0]  o_cpuData,
  output logic        o_rdy,
  output logic        o_cs,
  output logic        o_write,
  output logic [23:0] o_address,
  output logic [7:0]  o_dataToWrite,
  input  logic [7:0]  i_dataRead,
  input  logic        i_busy,
  input  logic        i_dataReady,
  output logic        o_error,
  output logic [15:0] o_accessCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        phi0_q, phi0_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] timer_q, timer_d;
  logic        seen_busy_q, seen_busy_d;
  logic        aborted_q, aborted_d;
  logic [7:0]  cpu_data_q, cpu_data_d;
  logic        rdy_q, rdy_d;
  logic        cs_q, cs_d;
  logic        write_q, write_d;
  logic [23:0] address_q, address_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        error_q, error_d;
  logic [15:0] count_q, count_d;

  logic req;
  logic timed_out;

  assign req       = i_phi0 && !phi0_q;
  assign timed_out = (timer_q == (TIMEOUT - 16'd1));

`ifndef GM64_VECTOR_OVERRIDE_EN
  // RESET_VECTOR has no effect in this build.
  logic unused_vector;
  assign unused_vector = ^RESET_VECTOR;
`endif

  always_comb begin
    state_d     = state_q;
    phi0_d      = i_phi0;
    addr_d      = addr_q;
    we_d        = we_q;
    data_d      = data_q;
    timer_d     = (state_q != S_IDLE) ? timer_q + 16'd1 : timer_q;
    seen_busy_d = seen_busy_q;
    aborted_d   = aborted_q;
    cpu_data_d  = cpu_data_q;
    rdy_d       = rdy_q;
    cs_d        = 1'b1;
    write_d     = write_q;
    address_d   = address_q;
    wdata_d     = wdata_q;
    error_d     = error_q;
    count_d     = count_q;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d      = i_addr;
          we_d        = i_we;
          data_d      = i_cpuData;
          rdy_d       = 1'b0;
          timer_d     = '0;
          seen_busy_d = 1'b0;
          aborted_d   = 1'b0;
          state_d     = S_ISSUE;
`ifdef GM64_VECTOR_OVERRIDE_EN
          if (!i_we && (i_addr[15:1] == 15'h7FFE)) begin
            cpu_data_d = i_addr[0] ? RESET_VECTOR[15:8] : RESET_VECTOR[7:0];
            state_d    = S_DONE;
          end
`endif
        end
      end

      S_ISSUE: begin
        if (timed_out) begin
          error_d   = 1'b1;
          aborted_d = 1'b1;
          if (!we_q) cpu_data_d = 8'hFF;
          state_d   = S_DONE;
        end else if (!i_busy) begin
          cs_d        = 1'b0;
          write_d     = we_q;
          address_d   = BASE_ADDR + {8'h00, addr_q};
          wdata_d     = data_q;
          seen_busy_d = 1'b0;
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (i_busy) seen_busy_d = 1'b1;
        // A completion seen on the same cycle as the timeout wins.
        if (!we_q && i_dataReady && !i_busy) begin
          cpu_data_d = i_dataRead;
          state_d    = S_DONE;
        end else if (we_q && seen_busy_q && !i_busy) begin
          state_d = S_DONE;
        end else if (timed_out) begin
          error_d   = 1'b1;
          aborted_d = 1'b1;
          if (!we_q) cpu_data_d = 8'hFF;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        rdy_d = 1'b1;
        if (!aborted_q) count_d = count_q + 16'd1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkSys or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      phi0_q      <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      data_q      <= '0;
      timer_q     <= '0;
      seen_busy_q <= 1'b0;
      aborted_q   <= 1'b0;
      cpu_data_q  <= '0;
      rdy_q       <= 1'b1;
      cs_q        <= 1'b1;
      write_q     <= 1'b0;
      address_q   <= '0;
      wdata_q     <= '0;
      error_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      phi0_q      <= phi0_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      data_q      <= data_d;
      timer_q     <= timer_d;
      seen_busy_q <= seen_busy_d;
      aborted_q   <= aborted_d;
      cpu_data_q  <= cpu_data_d;
      rdy_q       <= rdy_d;
      cs_q        <= cs_d;
      write_q     <= write_d;
      address_q   <= address_d;
      wdata_q     <= wdata_d;
      error_q     <= error_d;
      count_q     <= count_d;
    end
  end

  assign o_cpuData     = cpu_data_q;
  assign o_rdy         = rdy_q;
  assign o_cs          = cs_q;
  assign o_write       = write_q;
  assign o_address     = address_q;
  assign o_dataToWrite = wdata_q;
  assign o_error       = error_q;
  assign o_accessCount = count_q;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Testbench for cpu_bus_bridge: directed CPU bus cycles against a small
// memCtrl responder; expected completions are queued by the stimulus and
// checked by an independent monitor when o_rdy rises.
module tb_cpu_bus_bridge;

  logic        clkSys;
  logic        reset;
  logic        i_phi0;
  logic [15:0] i_addr;
  logic        i_we;
  logic [7:0]  i_cpuData;
  logic [7:0]  o_cpuData;
  logic        o_rdy;
  logic        o_cs;
  logic        o_write;
  logic [23:0] o_address;
  logic [7:0]  o_dataToWrite;
  logic [7:0]  i_dataRead;
  logic        i_busy;
  logic        i_dataReady;
  logic        o_error;
  logic [15:0] o_accessCount;

  logic        model_busy;
  logic        force_busy;
  logic        model_ready;
  logic [7:0]  model_data;
  int          resp_busy;
  logic        resp_ready;
  logic [7:0]  resp_data;

  assign i_busy      = model_busy | force_busy;
  assign i_dataReady = model_ready;
  assign i_dataRead  = model_data;

  cpu_bus_bridge #(
    .BASE_ADDR   (24'h000000),
    .TIMEOUT     (16'd16),
    .RESET_VECTOR(16'h0300)
  ) dut (
    .clkSys       (clkSys),
    .reset        (reset),
    .i_phi0       (i_phi0),
    .i_addr       (i_addr),
    .i_we         (i_we),
    .i_cpuData    (i_cpuData),
    .o_cpuData    (o_cpuData),
    .o_rdy        (o_rdy),
    .o_cs         (o_cs),
    .o_write      (o_write),
    .o_address    (o_address),
    .o_dataToWrite(o_dataToWrite),
    .i_dataRead   (i_dataRead),
    .i_busy       (i_busy),
    .i_dataReady  (i_dataReady),
    .o_error      (o_error),
    .o_accessCount(o_accessCount)
  );

  initial clkSys = 1'b0;
  always #5 clkSys = ~clkSys;

  typedef struct {
    logic [23:0] addr;
    logic        wr;
    logic [7:0]  wdata;
    int          cs_pulses;
    logic [7:0]  rdata;
    logic        err;
    logic [15:0] cnt;
    int          lat;   // o_rdy delay after busy/dataReady falls; -1 = skip
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input logic [23:0] a, input logic w, input logic [7:0] wd,
                            input int csn, input logic [7:0] rd, input logic e,
                            input logic [15:0] c, input int lat);
    exp_t x;
    x.addr = a; x.wr = w; x.wdata = wd; x.cs_pulses = csn;
    x.rdata = rd; x.err = e; x.cnt = c; x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic issue(input logic [15:0] a, input logic w, input logic [7:0] d);
    @(posedge clkSys); #1;
    i_addr = a; i_we = w; i_cpuData = d; i_phi0 = 1'b1;
    @(posedge clkSys); #1;
    i_phi0 = 1'b0;
  endtask

  task automatic wait_rdy();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clkSys);
      if (o_rdy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL rdy_timeout: o_rdy=0 after 200 cycles, expected 1");
    end
  endtask

  task automatic do_req(input logic [15:0] a, input logic w, input logic [7:0] d);
    issue(a, w, d);
    wait_rdy();
  endtask

  // memCtrl responder: on a cs pulse, busy for resp_busy cycles, then a
  // one-cycle dataReady with resp_data for reads (if resp_ready).
  initial begin
    logic wr;
    int   n;
    model_busy  = 1'b0;
    model_ready = 1'b0;
    model_data  = 8'h00;
    forever begin
      @(posedge clkSys); #1;
      model_ready = 1'b0;
      if (reset && !o_cs) begin
        wr = o_write;
        n  = resp_busy;
        model_busy = (n > 0);
        for (int i = 0; i < n && reset; i++) begin
          @(posedge clkSys); #1;
        end
        model_busy = 1'b0;
        if (reset && !wr && resp_ready) begin
          model_ready = 1'b1;
          model_data  = resp_data;
        end
      end
      if (!reset) begin
        model_busy  = 1'b0;
        model_ready = 1'b0;
      end
    end
  end

  // Monitor: counts cs pulses, captures request fields, checks each
  // completion (o_rdy rising) against the queued expectation.
  initial begin
    int          cyc;
    int          cs_cnt;
    int          fall_cyc;
    logic        prev_rdy;
    logic        prev_busy;
    logic [23:0] cap_addr;
    logic        cap_wr;
    logic [7:0]  cap_wdata;
    exp_t        e;
    cyc = 0; cs_cnt = 0; fall_cyc = 0; prev_rdy = 1'b1; prev_busy = 1'b0;
    cap_addr = '0; cap_wr = 1'b0; cap_wdata = '0;
    forever begin
      @(negedge clkSys);
      cyc++;
      if (!reset) begin
        cs_cnt    = 0;
        prev_rdy  = 1'b1;
        prev_busy = 1'b0;
        continue;
      end
      if (prev_busy && !i_busy) fall_cyc = cyc;
      if (model_ready) fall_cyc = cyc;
      prev_busy = i_busy;
      if (!o_cs) begin
        cs_cnt++;
        cap_addr  = o_address;
        cap_wr    = o_write;
        cap_wdata = o_dataToWrite;
      end
      if (o_rdy && !prev_rdy) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_completion: got completion, expected none");
        end else begin
          e = sb.pop_front();
          chk("cs_pulses", 32'(cs_cnt), 32'(e.cs_pulses));
          if (e.cs_pulses > 0) begin
            chk("o_address", 32'(cap_addr), 32'(e.addr));
            chk("o_write", 32'(cap_wr), 32'(e.wr));
            if (e.wr) chk("o_dataToWrite", 32'(cap_wdata), 32'(e.wdata));
          end
          chk("o_cpuData", 32'(o_cpuData), 32'(e.rdata));
          chk("o_error", 32'(o_error), 32'(e.err));
          chk("o_accessCount", 32'(o_accessCount), 32'(e.cnt));
          if (e.lat >= 0) chk("rdy_latency", 32'(cyc - fall_cyc), 32'(e.lat));
        end
        cs_cnt = 0;
      end
      prev_rdy = o_rdy;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0; miscompares = 0;
    i_phi0 = 1'b0; i_addr = '0; i_we = 1'b0; i_cpuData = '0;
    force_busy = 1'b0; resp_busy = 0; resp_ready = 1'b0; resp_data = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clkSys);
    #1;
    chk("reset_cs", 32'(o_cs), 32'h1);
    chk("reset_rdy", 32'(o_rdy), 32'h1);
    chk("reset_write", 32'(o_write), 32'h0);
    chk("reset_address", 32'(o_address), 32'h0);
    chk("reset_wdata", 32'(o_dataToWrite), 32'h0);
    chk("reset_cpuData", 32'(o_cpuData), 32'h0);
    chk("reset_error", 32'(o_error), 32'h0);
    chk("reset_count", 32'(o_accessCount), 32'h0);
    reset = 1'b1;

    // Plain read
    resp_busy = 3; resp_ready = 1'b1; resp_data = 8'hAA;
    expect_txn(24'h001234, 1'b0, 8'h00, 1, 8'hAA, 1'b0, 16'd1, 2);
    do_req(16'h1234, 1'b0, 8'h00);

    // Plain write: o_cpuData keeps the previous read value
    resp_busy = 4;
    expect_txn(24'h00D020, 1'b1, 8'h05, 1, 8'hAA, 1'b0, 16'd2, 2);
    do_req(16'hD020, 1'b1, 8'h05);

    // memCtrl busy when the request arrives
    resp_busy = 1; resp_ready = 1'b1; resp_data = 8'h3C;
    expect_txn(24'h000042, 1'b0, 8'h00, 1, 8'h3C, 1'b0, 16'd3, 2);
    @(posedge clkSys); #1;
    i_addr = 16'h0042; i_we = 1'b0; i_cpuData = 8'h00; i_phi0 = 1'b1; force_busy = 1'b1;
    @(posedge clkSys); #1;
    i_phi0 = 1'b0;
    repeat (9) @(posedge clkSys);
    #1 force_busy = 1'b0;
    @(negedge clkSys);
    chk("cs_while_busy", 32'(o_cs), 32'h1);
    @(negedge clkSys);
    chk("cs_after_busy", 32'(o_cs), 32'h0);
    @(negedge clkSys);
    chk("cs_pulse_end", 32'(o_cs), 32'h1);
    wait_rdy();

    // Reset-vector addresses
`ifdef GM64_VECTOR_OVERRIDE_EN
    expect_txn(24'h000000, 1'b0, 8'h00, 0, 8'h00, 1'b0, 16'd4, -1);
    do_req(16'hFFFC, 1'b0, 8'h00);
    expect_txn(24'h000000, 1'b0, 8'h00, 0, 8'h03, 1'b0, 16'd5, -1);
    do_req(16'hFFFD, 1'b0, 8'h00);
`else
    resp_busy = 2; resp_data = 8'h11;
    expect_txn(24'h00FFFC, 1'b0, 8'h00, 1, 8'h11, 1'b0, 16'd4, 2);
    do_req(16'hFFFC, 1'b0, 8'h00);
    resp_data = 8'h22;
    expect_txn(24'h00FFFD, 1'b0, 8'h00, 1, 8'h22, 1'b0, 16'd5, 2);
    do_req(16'hFFFD, 1'b0, 8'h00);
`endif

    // Timeout: read with no dataReady
    resp_busy = 2; resp_ready = 1'b0;
    expect_txn(24'h000100, 1'b0, 8'h00, 1, 8'hFF, 1'b1, 16'd5, -1);
    do_req(16'h0100, 1'b0, 8'h00);

    // Reset while waiting on memCtrl
    resp_busy = 6; resp_ready = 1'b1; resp_data = 8'h99;
    issue(16'h0200, 1'b0, 8'h00);
    repeat (2) @(posedge clkSys);
    #2;
    chk("mid_wait_rdy", 32'(o_rdy), 32'h0);
    reset = 1'b0;
    #1;
    chk("mid_reset_cs", 32'(o_cs), 32'h1);
    chk("mid_reset_rdy", 32'(o_rdy), 32'h1);
    chk("mid_reset_error", 32'(o_error), 32'h0);
    chk("mid_reset_count", 32'(o_accessCount), 32'h0);
    chk("mid_reset_cpuData", 32'(o_cpuData), 32'h0);
    @(posedge clkSys);
    #2 reset = 1'b1;

    // Normal operation after reset
    resp_busy = 2; resp_ready = 1'b1; resp_data = 8'h5A;
    expect_txn(24'h000300, 1'b0, 8'h00, 1, 8'h5A, 1'b0, 16'd1, 2);
    do_req(16'h0300, 1'b0, 8'h00);
    resp_busy = 1;
    expect_txn(24'h000007, 1'b1, 8'h77, 1, 8'h5A, 1'b0, 16'd2, 2);
    do_req(16'h0007, 1'b1, 8'h77);
    resp_data = 8'hC3;
    expect_txn(24'h00FFFF, 1'b0, 8'h00, 1, 8'hC3, 1'b0, 16'd3, 2);
    do_req(16'hFFFF, 1'b0, 8'h00);

    repeat (3) @(negedge clkSys);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
